// File: rtl/png_chunk_pack.sv
// ============================================================================
// Module     : png_chunk_pack
// Description: Frames one PNG chunk (LENGTH, TYPE, DATA..., CRC) onto a 32-bit
//              stream and drives an external crc32 engine over TYPE+DATA.
//              Optional payload length check: define PNG_CHUNK_LEN_CHK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module png_chunk_pack #(
    parameter int DATA_WD = 32,
    parameter int CRC_CYC = 4,
    parameter int LEN_WD  = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [LEN_WD-1:0]  len_i,
    input  logic [DATA_WD-1:0] typ_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    output logic               rdy_o,
    output logic               crc_start_o,
    output logic               crc_val_o,
    output logic [DATA_WD-1:0] crc_dat_o,
    output logic               crc_lst_o,
    input  logic               crc_done_i,
    input  logic               crc_val_i,
    input  logic [DATA_WD-1:0] crc_dat_i,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic               lst_o,
    output logic               busy_o,
    output logic               done_o
`ifdef PNG_CHUNK_LEN_CHK_EN
    ,
    output logic               err_o
`endif
);

    localparam int CNT_W = (CRC_CYC > 1) ? $clog2(CRC_CYC) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CRC_CYC - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_TYP  = 3'd2;
    localparam logic [2:0] c_DAT  = 3'd3;
    localparam logic [2:0] c_WCRC = 3'd4;
    localparam logic [2:0] c_CRC  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_nxt_state;
    logic [LEN_WD-1:0]  r_len;
    logic [DATA_WD-1:0] r_word;   // word currently presented to crc32 (type, then payload)
    logic               r_wlst;
    logic [CNT_W-1:0]   r_cnt;    // position inside the current crc32 window
    logic               r_win;    // payload window active
    logic               r_last;   // last payload word has been accepted
    logic [DATA_WD-1:0] r_crc;
    logic               w_cnt_end;

    assign w_cnt_end = (r_cnt == c_CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            c_IDLE: if (start_i) w_nxt_state = c_LEN;
            c_LEN:  w_nxt_state = c_TYP;
            c_TYP:  if (w_cnt_end) w_nxt_state = (r_len == '0) ? c_WCRC : c_DAT;
            c_DAT:  if (r_win && w_cnt_end && r_last) w_nxt_state = c_WCRC;
            c_WCRC: if (crc_done_i && crc_val_i) w_nxt_state = c_CRC;
            c_CRC:  w_nxt_state = c_IDLE;
            default: w_nxt_state = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rdy_o       = 1'b0;
        crc_start_o = 1'b0;
        crc_val_o   = 1'b0;
        crc_dat_o   = '0;
        crc_lst_o   = 1'b0;
        val_o       = 1'b0;
        dat_o       = '0;
        lst_o       = 1'b0;
        done_o      = 1'b0;
        busy_o      = (r_state != c_IDLE);
        case (r_state)
            c_LEN: begin
                crc_start_o = 1'b1;
                val_o       = 1'b1;
                dat_o       = DATA_WD'(r_len);
            end
            c_TYP: begin
                crc_val_o = 1'b1;
                crc_dat_o = r_word;
                crc_lst_o = r_wlst;
                val_o     = (r_cnt == '0);
                dat_o     = (r_cnt == '0) ? r_word : '0;
            end
            c_DAT: begin
                rdy_o = !r_win;
                if (r_win) begin
                    crc_val_o = 1'b1;
                    crc_dat_o = r_word;
                    crc_lst_o = r_wlst;
                    val_o     = (r_cnt == '0);
                    dat_o     = (r_cnt == '0) ? r_word : '0;
                end
            end
            c_CRC: begin
                val_o  = 1'b1;
                dat_o  = r_crc;
                lst_o  = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latched header, window sequencing, captured CRC
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len  <= '0;
            r_word <= '0;
            r_wlst <= 1'b0;
            r_cnt  <= '0;
            r_win  <= 1'b0;
            r_last <= 1'b0;
            r_crc  <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (start_i) begin
                    r_len  <= len_i;
                    r_word <= typ_i;
                    r_wlst <= (len_i == '0);
                    r_cnt  <= '0;
                    r_win  <= 1'b0;
                    r_last <= 1'b0;
                end
                c_TYP: r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                c_DAT: begin
                    if (r_win) begin
                        r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                        if (w_cnt_end) r_win <= 1'b0;
                    end else if (val_i) begin
                        r_win  <= 1'b1;
                        r_cnt  <= '0;
                        r_word <= dat_i;
                        r_wlst <= lst_i;
                        r_last <= lst_i;
                    end
                end
                c_WCRC: if (crc_done_i && crc_val_i) r_crc <= crc_dat_i;
                default: ;
            endcase
        end
    end

`ifdef PNG_CHUNK_LEN_CHK_EN
    logic [LEN_WD-3:0] r_wcnt;
    logic              r_err;

    // Accepted-word count versus declared length, judged when the CRC arrives
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == c_IDLE && start_i) begin
                r_wcnt <= '0;
                r_err  <= 1'b0;
            end else if (r_state == c_DAT && !r_win && val_i) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_state == c_WCRC && crc_done_i && crc_val_i) begin
                r_err <= (r_wcnt != r_len[LEN_WD-1:2]);
            end
        end
    end

    assign err_o = r_err;
`endif

endmodule

`default_nettype wire
